nlms_bram_slave_if: RTL and testbench
=====================================

// Module: nlms_bram_slave_if
// PURPOSE
//  BRAM-port responder at the host boundary of nlms_top. Port A is write-only: each write is decoded into
//  sample-buffer write strobes (X, D, H, X-FIFO) or a config/control register update. Port B is read-only:
//  it returns output-buffer samples or register contents with 1-cycle BRAM read latency.
//  Generates the core start pulse and keeps the host-visible status register.
// PARAMETERS
//  LOG2_H_BUFF_HEIGHT    7   log2 depth of H and X-FIFO buffers (words)
//  LOG2_X_D_BUFF_HEIGHT  7   log2 depth of X, D and OUT buffers (words)
//  SAMPLE_WIDTH          16  sample width; must be a multiple of 8 and <= BRAM_DATA_WIDTH
//  BRAM_ADDR_WIDTH       12  byte address width
//  BRAM_DATA_WIDTH       32  data word width
// PORTS
//  bram_clk_a     in   1    sole clock; port B logic also runs on this clock
//  bram_rst_a     in   1    synchronous, active-high reset
//  bram_en_a      in   1    port A enable
//  bram_we_a      in   4    port A byte write enables
//  bram_addr_a    in   12   port A byte address
//  bram_wrdata_a  in   32   port A write data
//  bram_rddata_a  out  32   tied 0
//  bram_en_b      in   1    port B enable
//  bram_addr_b    in   12   port B byte address
//  bram_rddata_b  out  32   port B read data, valid 1 cycle after en_b
//  buf_waddr      out  7    sample-buffer word address (addr_a[8:2])
//  buf_wdata      out  16   sample = wrdata_a[SAMPLE_WIDTH-1:0]
//  x_we,d_we,h_we,xf_we out 1 each  one-cycle write strobes to X / D / H / X-FIFO buffers
//  out_re         out  1    output-buffer read enable (combinational from port B)
//  out_raddr      out  7    output-buffer word address (addr_b[8:2])
//  out_rdata      in   16   output-buffer data, 1 cycle after out_re
//  cfg_reg        out  16   config: [1:0] op, [2] y_as_out, [3] x_u2, [4] x_fract, [8:5] in_bits
//  x_count        out  16   number of X samples
//  h_blocks       out  16   number of H-coefficient blocks
//  mi, gamma      out  16 each  step size / regularisation (Q format)
//  core_start     out  1    one-cycle start pulse to the core
//  core_busy      in   1    core running
//  core_done      in   1    one-cycle completion pulse
// BEHAVIOUR
//  Map (byte addr, word = addr>>2, addr[1:0] ignored): X 0x000, D 0x200, H 0x400, XF 0x600, OUT 0x800,
//   CFG 0xA00, XCNT 0xA04, HBLK 0xA08, CTRL 0xA0C, STATUS 0xA10, MI 0xA14, GAMMA 0xA18; other addresses are unmapped.
//  Reset: all outputs 0; registers 0; status 0; rddata_b 0.
//  Port A write = en_a & |we_a. Buffer region: strobe, addr and data are registered, so the buffer write lands
//   1 cycle after the port A write. The strobe is issued only if we_a[SAMPLE_WIDTH/8-1:0] is all ones; otherwise
//   the write is dropped. Register region: byte-wise update of the low 16 bits under we_a[1:0]. Port A writes to
//   OUT, STATUS or unmapped addresses are ignored.
//  CTRL write with wrdata[0]=1 and we_a[0]:
//   - if !core_busy and !start_pending: core_start=1 on the next cycle for exactly 1 cycle; done is cleared.
//   - if core_busy: the start is ignored and err is set.
//  CTRL always reads back 0.
//  STATUS = {29'b0, err, done, core_busy}.
//   - done sets on core_done and stays set until the next accepted start.
//   - err is sticky; cleared by a STATUS read or by reset.
//   - If core_done and a STATUS read occur in the same cycle, done sets and the read returns the old value.
//  Port B read = en_b, latency 1.
//   - OUT region: out_re=1 in the same cycle; rddata_b = zero-extended out_rdata next cycle.
//   - Registers: rddata_b is the registered, zero-extended value.
//   - X/D/H/XF and unmapped addresses return 0.
//   - When en_b=0, rddata_b holds its last value.
//  Simultaneous port A write and port B read of the same register: the read returns the pre-write value.
//  Reset while the core is busy: all registers clear and core_start stays 0. The parent also resets the core.
// TESTING
//  1. Write X[0..15] = (i+1)*256 at 0x000+4i -> x_we pulses 16x, buf_waddr 0..15, buf_wdata 256..4096 one cycle later.
//  2. Write CFG=0x1FD, XCNT=16, HBLK=3, MI=128; read each on port B -> 0x1FD, 16, 3, 128 one cycle after en_b.
//  3. CTRL=1 while idle -> single core_start pulse; drive core_busy for 100 cycles, then core_done -> STATUS reads 1 while busy, then 2 after done.
//  4. CTRL=1 while core_busy -> no core_start; STATUS=5; read STATUS again -> 1 (err cleared).
//  5. Preload OUT[3]=0xBEEF and read 0x80C -> out_re with out_raddr=3; rddata_b=0x0000BEEF next cycle.
//  6. Write we_a=4'b0001 to the H region -> no h_we. Write to 0xFFC -> no strobes, reads back 0. Reset mid-test -> all regs 0.

Source files
------------

// File: rtl/nlms_bram_slave_if.sv
// Host-side BRAM responder for nlms_top: port A decodes writes into buffer strobes or
// config/control updates, port B returns output samples or register contents one cycle later.
module nlms_bram_slave_if #(
  parameter int LOG2_H_BUFF_HEIGHT   = 7,
  parameter int LOG2_X_D_BUFF_HEIGHT = 7,
  parameter int SAMPLE_WIDTH         = 16,
  parameter int BRAM_ADDR_WIDTH      = 12,
  parameter int BRAM_DATA_WIDTH      = 32,
  parameter int BUF_AW = (LOG2_H_BUFF_HEIGHT > LOG2_X_D_BUFF_HEIGHT) ?
                         LOG2_H_BUFF_HEIGHT : LOG2_X_D_BUFF_HEIGHT
) (
  input  logic                         bram_clk_a,
  input  logic                         bram_rst_a,
  input  logic                         bram_en_a,
  input  logic [BRAM_DATA_WIDTH/8-1:0] bram_we_a,
  input  logic [BRAM_ADDR_WIDTH-1:0]   bram_addr_a,
  input  logic [BRAM_DATA_WIDTH-1:0]   bram_wrdata_a,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_rddata_a,
  input  logic                         bram_en_b,
  input  logic [BRAM_ADDR_WIDTH-1:0]   bram_addr_b,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_rddata_b,
  output logic [BUF_AW-1:0]            buf_waddr,
  output logic [SAMPLE_WIDTH-1:0]      buf_wdata,
  output logic                         x_we,
  output logic                         d_we,
  output logic                         h_we,
  output logic                         xf_we,
  output logic                         out_re,
  output logic [LOG2_X_D_BUFF_HEIGHT-1:0] out_raddr,
  input  logic [SAMPLE_WIDTH-1:0]      out_rdata,
  output logic [15:0]                  cfg_reg,
  output logic [15:0]                  x_count,
  output logic [15:0]                  h_blocks,
  output logic [15:0]                  mi,
  output logic [15:0]                  gamma,
  output logic                         core_start,
  input  logic                         core_busy,
  input  logic                         core_done
);

  localparam int SB = SAMPLE_WIDTH / 8;
  localparam int BW = BRAM_DATA_WIDTH / 8;

  typedef enum logic [3:0] {
    R_X, R_D, R_H, R_XF, R_OUT, R_CFG, R_XCNT, R_HBLK, R_CTRL, R_STATUS, R_MI, R_GAMMA, R_NONE
  } region_e;

  function automatic region_e decode(input logic [BRAM_ADDR_WIDTH-1:0] a);
    region_e r;
    case (a[11:9])
      3'd0: r = R_X;
      3'd1: r = R_D;
      3'd2: r = R_H;
      3'd3: r = R_XF;
      3'd4: r = R_OUT;
      3'd5: begin
        case (a[8:2])
          7'd0:    r = R_CFG;
          7'd1:    r = R_XCNT;
          7'd2:    r = R_HBLK;
          7'd3:    r = R_CTRL;
          7'd4:    r = R_STATUS;
          7'd5:    r = R_MI;
          7'd6:    r = R_GAMMA;
          default: r = R_NONE;
        endcase
      end
      default: r = R_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] byte_upd(input logic [15:0] old,
                                           input logic [BRAM_DATA_WIDTH-1:0] wd,
                                           input logic [BW-1:0] we);
    logic [15:0] n;
    n[7:0]  = we[0] ? wd[7:0]  : old[7:0];
    n[15:8] = we[1] ? wd[15:8] : old[15:8];
    return n;
  endfunction

  logic [15:0] cfg_q, cfg_d, xcnt_q, xcnt_d, hblk_q, hblk_d, mi_q, mi_d, gamma_q, gamma_d;
  logic x_we_q, x_we_d, d_we_q, d_we_d, h_we_q, h_we_d, xf_we_q, xf_we_d;
  logic [BUF_AW-1:0] buf_waddr_q, buf_waddr_d;
  logic [SAMPLE_WIDTH-1:0] buf_wdata_q, buf_wdata_d;
  logic start_q, start_d, pending_q, pending_d, done_q, done_d, err_q, err_d;
  logic out_pend_q, out_pend_d;
  logic [BRAM_DATA_WIDTH-1:0] hold_q, hold_d;

  region_e reg_a_s, reg_b_s;
  logic wr_s, full_s, buf_s, err_set_s, done_clr_s, status_rd_s;
  logic [BRAM_DATA_WIDTH-1:0] out_ext_s, rd_val_s, status_s;

  always_comb begin
    reg_a_s     = decode(bram_addr_a);
    reg_b_s     = decode(bram_addr_b);
    wr_s        = bram_en_a & (|bram_we_a);
    full_s      = &bram_we_a[SB-1:0];
    buf_s       = (reg_a_s == R_X) || (reg_a_s == R_D) || (reg_a_s == R_H) || (reg_a_s == R_XF);
    status_rd_s = bram_en_b && (reg_b_s == R_STATUS);
    out_ext_s   = {{(BRAM_DATA_WIDTH-SAMPLE_WIDTH){1'b0}}, out_rdata};
    status_s    = {{(BRAM_DATA_WIDTH-3){1'b0}}, err_q, done_q, core_busy};

    cfg_d = cfg_q; xcnt_d = xcnt_q; hblk_d = hblk_q; mi_d = mi_q; gamma_d = gamma_q;
    x_we_d = 1'b0; d_we_d = 1'b0; h_we_d = 1'b0; xf_we_d = 1'b0;
    start_d    = 1'b0;
    err_set_s  = 1'b0;
    done_clr_s = 1'b0;
    pending_d  = pending_q & ~(core_busy | core_done);

    if (wr_s) begin
      case (reg_a_s)
        R_X:     x_we_d  = full_s;
        R_D:     d_we_d  = full_s;
        R_H:     h_we_d  = full_s;
        R_XF:    xf_we_d = full_s;
        R_CFG:   cfg_d   = byte_upd(cfg_q, bram_wrdata_a, bram_we_a);
        R_XCNT:  xcnt_d  = byte_upd(xcnt_q, bram_wrdata_a, bram_we_a);
        R_HBLK:  hblk_d  = byte_upd(hblk_q, bram_wrdata_a, bram_we_a);
        R_MI:    mi_d    = byte_upd(mi_q, bram_wrdata_a, bram_we_a);
        R_GAMMA: gamma_d = byte_upd(gamma_q, bram_wrdata_a, bram_we_a);
        R_CTRL: begin
          // A start while a previous one is still pending and the core is idle is silently dropped
          if (bram_we_a[0] && bram_wrdata_a[0]) begin
            if (core_busy) begin
              err_set_s = 1'b1;
            end else if (!pending_q) begin
              start_d    = 1'b1;
              pending_d  = 1'b1;
              done_clr_s = 1'b1;
            end else begin
              start_d = 1'b0;
            end
          end else begin
            start_d = 1'b0;
          end
        end
        default: start_d = 1'b0;
      endcase
    end else begin
      start_d = 1'b0;
    end

    if (wr_s && buf_s && full_s) begin
      buf_waddr_d = bram_addr_a[BUF_AW+1:2];
      buf_wdata_d = bram_wrdata_a[SAMPLE_WIDTH-1:0];
    end else begin
      buf_waddr_d = buf_waddr_q;
      buf_wdata_d = buf_wdata_q;
    end

    if (core_done) begin
      done_d = 1'b1;
    end else if (done_clr_s) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end

    if (err_set_s) begin
      err_d = 1'b1;
    end else if (status_rd_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    case (reg_b_s)
      R_CFG:    rd_val_s = {{(BRAM_DATA_WIDTH-16){1'b0}}, cfg_q};
      R_XCNT:   rd_val_s = {{(BRAM_DATA_WIDTH-16){1'b0}}, xcnt_q};
      R_HBLK:   rd_val_s = {{(BRAM_DATA_WIDTH-16){1'b0}}, hblk_q};
      R_MI:     rd_val_s = {{(BRAM_DATA_WIDTH-16){1'b0}}, mi_q};
      R_GAMMA:  rd_val_s = {{(BRAM_DATA_WIDTH-16){1'b0}}, gamma_q};
      R_STATUS: rd_val_s = status_s;
      default:  rd_val_s = {BRAM_DATA_WIDTH{1'b0}};
    endcase

    // Hold captures streamed OUT data so the last read value persists while en_b is low
    out_pend_d = bram_en_b && (reg_b_s == R_OUT);
    if (bram_en_b && (reg_b_s != R_OUT)) begin
      hold_d = rd_val_s;
    end else if (out_pend_q) begin
      hold_d = out_ext_s;
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge bram_clk_a) begin
    if (bram_rst_a) begin
      cfg_q <= 16'd0; xcnt_q <= 16'd0; hblk_q <= 16'd0; mi_q <= 16'd0; gamma_q <= 16'd0;
      x_we_q <= 1'b0; d_we_q <= 1'b0; h_we_q <= 1'b0; xf_we_q <= 1'b0;
      buf_waddr_q <= {BUF_AW{1'b0}};
      buf_wdata_q <= {SAMPLE_WIDTH{1'b0}};
      start_q <= 1'b0; pending_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      out_pend_q <= 1'b0;
      hold_q <= {BRAM_DATA_WIDTH{1'b0}};
    end else begin
      cfg_q <= cfg_d; xcnt_q <= xcnt_d; hblk_q <= hblk_d; mi_q <= mi_d; gamma_q <= gamma_d;
      x_we_q <= x_we_d; d_we_q <= d_we_d; h_we_q <= h_we_d; xf_we_q <= xf_we_d;
      buf_waddr_q <= buf_waddr_d;
      buf_wdata_q <= buf_wdata_d;
      start_q <= start_d; pending_q <= pending_d; done_q <= done_d; err_q <= err_d;
      out_pend_q <= out_pend_d;
      hold_q <= hold_d;
    end
  end

  assign bram_rddata_a = {BRAM_DATA_WIDTH{1'b0}};
  assign bram_rddata_b = out_pend_q ? out_ext_s : hold_q;
  assign out_re        = bram_en_b && (reg_b_s == R_OUT);
  assign out_raddr     = bram_addr_b[LOG2_X_D_BUFF_HEIGHT+1:2];
  assign buf_waddr     = buf_waddr_q;
  assign buf_wdata     = buf_wdata_q;
  assign x_we          = x_we_q;
  assign d_we          = d_we_q;
  assign h_we          = h_we_q;
  assign xf_we         = xf_we_q;
  assign cfg_reg       = cfg_q;
  assign x_count       = xcnt_q;
  assign h_blocks      = hblk_q;
  assign mi            = mi_q;
  assign gamma         = gamma_q;
  assign core_start    = start_q;

endmodule

// File: tb/tb_nlms_bram_slave_if.sv
// Directed bench for nlms_bram_slave_if with a small output-buffer model on port B.
module tb_nlms_bram_slave_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a;
  logic [3:0]  we_a;
  logic [11:0] addr_a;
  logic [31:0] wrdata_a;
  logic [31:0] rddata_a;
  logic        en_b;
  logic [11:0] addr_b;
  logic [31:0] rddata_b;
  logic [6:0]  buf_waddr;
  logic [15:0] buf_wdata;
  logic        x_we, d_we, h_we, xf_we;
  logic        out_re;
  logic [6:0]  out_raddr;
  logic [15:0] out_rdata;
  logic [15:0] cfg_reg, x_count, h_blocks, mi, gamma;
  logic        core_start;
  logic        core_busy;
  logic        core_done;

  logic [15:0] out_mem [0:127];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          start_cnt = 0;
  logic [31:0] d;

  always #5 clk = ~clk;

  nlms_bram_slave_if dut (
    .bram_clk_a(clk), .bram_rst_a(rst),
    .bram_en_a(en_a), .bram_we_a(we_a), .bram_addr_a(addr_a), .bram_wrdata_a(wrdata_a),
    .bram_rddata_a(rddata_a),
    .bram_en_b(en_b), .bram_addr_b(addr_b), .bram_rddata_b(rddata_b),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .x_we(x_we), .d_we(d_we), .h_we(h_we), .xf_we(xf_we),
    .out_re(out_re), .out_raddr(out_raddr), .out_rdata(out_rdata),
    .cfg_reg(cfg_reg), .x_count(x_count), .h_blocks(h_blocks), .mi(mi), .gamma(gamma),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done)
  );

  // Output buffer: one-cycle read latency
  always @(posedge clk) begin
    if (out_re) out_rdata <= out_mem[out_raddr];
  end

  always @(posedge clk) begin
    if (core_start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v, input logic [3:0] we);
    en_a = 1'b1; we_a = we; addr_a = a; wrdata_a = v;
    step();
    en_a = 1'b0; we_a = 4'h0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    en_b = 1'b1; addr_b = a;
    step();
    en_b = 1'b0;
    v = rddata_b;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) out_mem[i] = 16'h0000;
    out_mem[3] = 16'hBEEF;
    out_rdata = 16'h0000;
    rst = 1'b1; en_a = 1'b0; we_a = 4'h0; addr_a = 12'h000; wrdata_a = 32'h0;
    en_b = 1'b0; addr_b = 12'h000; core_busy = 1'b0; core_done = 1'b0;
    step(); step();
    rst = 1'b0;

    chk("reset_cfg", {16'h0, cfg_reg}, 32'h0);
    chk("reset_start", {31'h0, core_start}, 32'h0);
    chk("reset_strobes", {28'h0, x_we, d_we, h_we, xf_we}, 32'h0);
    chk("reset_rddata_b", rddata_b, 32'h0);
    chk("rddata_a_zero", rddata_a, 32'h0);

    // 1. X buffer writes
    for (int i = 0; i < 16; i++) begin
      wr(12'(4 * i), 32'((i + 1) * 256), 4'hF);
      chk("x_we", {31'h0, x_we}, 32'h1);
      chk("x_waddr", {25'h0, buf_waddr}, 32'(i));
      chk("x_wdata", {16'h0, buf_wdata}, 32'((i + 1) * 256));
      chk("x_other_we", {29'h0, d_we, h_we, xf_we}, 32'h0);
    end
    step();
    chk("x_we_drop", {31'h0, x_we}, 32'h0);
    wr(12'h208, 32'h0000_1234, 4'h3);
    chk("d_we", {28'h0, x_we, d_we, h_we, xf_we}, 32'h4);
    chk("d_waddr", {25'h0, buf_waddr}, 32'h2);
    wr(12'h604, 32'h0000_5678, 4'hF);
    chk("xf_we", {28'h0, x_we, d_we, h_we, xf_we}, 32'h1);

    // 2. Register writes and readback
    wr(12'hA00, 32'h0000_01FD, 4'hF);
    wr(12'hA04, 32'd16, 4'hF);
    wr(12'hA08, 32'd3, 4'hF);
    wr(12'hA14, 32'd128, 4'hF);
    chk("cfg_out", {16'h0, cfg_reg}, 32'h1FD);
    rd(12'hA00, d); chk("rd_cfg", d, 32'h1FD);
    rd(12'hA04, d); chk("rd_xcnt", d, 32'd16);
    rd(12'hA08, d); chk("rd_hblk", d, 32'd3);
    rd(12'hA14, d); chk("rd_mi", d, 32'd128);
    wr(12'hA18, 32'hFFFF_ABCD, 4'h2);
    chk("gamma_byte", {16'h0, gamma}, 32'hAB00);
    rd(12'hA0C, d); chk("rd_ctrl", d, 32'h0);

    // Same-cycle write and read of XCNT returns the old value
    en_a = 1'b1; we_a = 4'hF; addr_a = 12'hA04; wrdata_a = 32'h55;
    en_b = 1'b1; addr_b = 12'hA04;
    step();
    en_a = 1'b0; we_a = 4'h0; en_b = 1'b0;
    chk("rw_same_old", rddata_b, 32'd16);
    chk("rw_same_new", {16'h0, x_count}, 32'h55);
    step();
    chk("rd_hold", rddata_b, 32'd16);

    // 3. Start while idle
    wr(12'hA0C, 32'h1, 4'hF);
    chk("start_pulse", {31'h0, core_start}, 32'h1);
    core_busy = 1'b1;
    step();
    chk("start_single", {31'h0, core_start}, 32'h0);
    rd(12'hA10, d); chk("status_busy", d, 32'h1);
    for (int i = 0; i < 97; i++) step();
    rd(12'hA10, d); chk("status_busy_late", d, 32'h1);
    core_busy = 1'b0; core_done = 1'b1;
    step();
    core_done = 1'b0;
    rd(12'hA10, d); chk("status_done", d, 32'h2);
    chk("start_count", 32'(start_cnt), 32'd1);

    // 4. Start while busy
    wr(12'hA0C, 32'h1, 4'h1);
    chk("start2_pulse", {31'h0, core_start}, 32'h1);
    core_busy = 1'b1;
    step();
    wr(12'hA0C, 32'h1, 4'h1);
    step();
    chk("busy_no_start", {31'h0, core_start}, 32'h0);
    rd(12'hA10, d); chk("status_err", d, 32'h5);
    rd(12'hA10, d); chk("status_err_clr", d, 32'h1);
    chk("start_count2", 32'(start_cnt), 32'd2);
    core_busy = 1'b0;
    step();

    // 5. Output buffer read
    en_b = 1'b1; addr_b = 12'h80C;
    #1;
    chk("out_re", {31'h0, out_re}, 32'h1);
    chk("out_raddr", {25'h0, out_raddr}, 32'h3);
    step();
    en_b = 1'b0;
    chk("out_rdata", rddata_b, 32'h0000_BEEF);
    #1;
    chk("out_re_idle", {31'h0, out_re}, 32'h0);
    step(); step();
    chk("out_hold", rddata_b, 32'h0000_BEEF);

    // 6. Partial write, unmapped access, reset while busy
    wr(12'h400, 32'h0000_7777, 4'h1);
    chk("h_partial", {28'h0, x_we, d_we, h_we, xf_we}, 32'h0);
    wr(12'h404, 32'h0000_7777, 4'h3);
    chk("h_full", {28'h0, x_we, d_we, h_we, xf_we}, 32'h2);
    wr(12'hFFC, 32'hFFFF_FFFF, 4'hF);
    chk("unmapped_strobes", {28'h0, x_we, d_we, h_we, xf_we}, 32'h0);
    rd(12'hFFC, d); chk("rd_unmapped", d, 32'h0);
    rd(12'h000, d); chk("rd_xregion", d, 32'h0);
    chk("cfg_kept", {16'h0, cfg_reg}, 32'h1FD);

    core_busy = 1'b1;
    wr(12'hA0C, 32'h1, 4'hF);
    rst = 1'b1;
    step();
    chk("rst_busy_start", {31'h0, core_start}, 32'h0);
    rst = 1'b0; core_busy = 1'b0;
    chk("rst_regs", {cfg_reg, x_count}, 32'h0);
    chk("rst_regs2", {h_blocks, mi}, 32'h0);
    chk("rst_gamma", {16'h0, gamma}, 32'h0);
    rd(12'hA10, d); chk("rst_status", d, 32'h0);
    rd(12'hA00, d); chk("rst_rd_cfg", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
